ixc_context_write: RTL and testbench

- Restore-side counterpart of the context capture path. Capture writes a design's state bits into a 32-bit-wide context memory word; this block does the reverse.
- On request it reads the context word(s) back through a memory read port and repacks them into a DATA_W-bit value.
- It then drives that value into the target state elements through a load/acknowledge handshake.
- It sits between the emulator context memory (read side) and the per-module state-injection logic.

---
 rtl/ixc_context_pkg.sv | 27 ++
 rtl/ixc_ctx_ack_timer.sv | 32 +++
 rtl/ixc_context_write.sv | 145 ++++++++++++++
 tb/tb_ixc_context_write.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ixc_context_pkg.sv
// Shared definitions for the context capture/restore paths: restore FSM
// states and the word-count arithmetic used to size memory accesses.
package ixc_context_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_CAPT = 3'd2,
        ST_LOAD = 3'd3,
        ST_FIN  = 3'd4
    } ctx_state_e;

    // Number of b-bit words needed to hold a bits, never less than one.
    function automatic int ceil_div(input int a, input int b);
        int r;
        r = (a + b - 1) / b;
        return (r < 1) ? 1 : r;
    endfunction

    // clog2 that never returns 0, so single-entry ranges still get a bit.
    function automatic int safe_clog2(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/ixc_ctx_ack_timer.sv
// Loadable down-counter watching for the load acknowledge. expire is high
// while the count sits at zero; the counter stops there.
module ixc_ctx_ack_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;

    // Clear has priority over load, load over counting down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/ixc_context_write.sv
// Context restore engine: reads NUM_WORDS context memory words, repacks
// them into a DATA_W-bit value and loads it into the target state.
//
// Target handshake: ctx_we is a request held with ctx_wdata stable until
// the cycle ctx_ack is seen (that cycle completes the load) or until
// ACK_TMO request cycles pass without ctx_ack, which ends the restore
// with err set. An ack on the final timeout cycle counts as success.
module ixc_context_write
    import ixc_context_pkg::*;
#(
    parameter int  DATA_W    = 6,
    parameter int  WORD_W    = 32,
    parameter int  ACK_TMO   = 15,
    localparam int NUM_WORDS = ceil_div(DATA_W, WORD_W),
    localparam int ADDR_W    = safe_clog2(NUM_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WORD_W-1:0] rd_data,
    output logic [DATA_W-1:0] ctx_wdata,
    output logic              ctx_we,
    input  logic              ctx_ack,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int                PACK_W   = NUM_WORDS * WORD_W;
    localparam int                TMR_W    = safe_clog2(ACK_TMO);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);
    localparam logic [TMR_W-1:0]  TMR_INIT = TMR_W'(ACK_TMO - 1);

    ctx_state_e        state;
    ctx_state_e        state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] last_addr;
    logic [PACK_W-1:0] pack;
    logic              err_q;
    logic              last_word;
    logic              accept;
    logic              ack_ok;
    logic              tmo_hit;
    logic              tmr_clear;
    logic              tmr_load;
    logic              tmr_en;
    logic              tmr_expire;
    logic              unused_pack;

    assign last_word = (idx == LAST_IDX);
    assign accept    = (state == ST_IDLE) && start;
    assign ack_ok    = (state == ST_LOAD) && ctx_ack;
    assign tmo_hit   = (state == ST_LOAD) && !ctx_ack && tmr_expire;

    // Timer is armed with ACK_TMO-1 on entry to LOAD, so expire marks the
    // ACK_TMO-th request cycle.
    assign tmr_clear = (state == ST_FIN);
    assign tmr_load  = (state == ST_CAPT) && last_word;
    assign tmr_en    = (state == ST_LOAD);

    ixc_ctx_ack_timer #(
        .CNT_W (TMR_W)
    ) u_ack_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (tmr_clear),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (TMR_INIT),
        .expire   (tmr_expire)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one READ/CAPT pair per word, then LOAD until ack or timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_READ;
            ST_READ: state_nxt = ST_CAPT;
            ST_CAPT: state_nxt = last_word ? ST_LOAD : ST_READ;
            ST_LOAD: if (ack_ok || tmo_hit) state_nxt = ST_FIN;
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: strobes and status are pure functions of the state.
    always_comb begin
        rd_en  = 1'b0;
        ctx_we = 1'b0;
        done   = 1'b0;
        busy   = (state != ST_IDLE);
        case (state)
            ST_READ: rd_en  = 1'b1;
            ST_LOAD: ctx_we = 1'b1;
            ST_FIN:  done   = 1'b1;
            default: ;
        endcase
    end

    // Word index, held read address, pack register and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            last_addr <= '0;
            pack      <= '0;
            err_q     <= 1'b0;
        end else begin
            if (accept || (state == ST_FIN)) begin
                idx <= '0;
            end else if ((state == ST_CAPT) && !last_word) begin
                idx <= idx + 1'b1;
            end
            if (state == ST_READ) begin
                last_addr <= idx;
            end
            if (state == ST_CAPT) begin
                pack[idx * WORD_W +: WORD_W] <= rd_data;
            end
            if (accept) begin
                err_q <= 1'b0;
            end else if (tmo_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign rd_addr   = rd_en ? idx : last_addr;
    assign ctx_wdata = (state == ST_LOAD) ? pack[DATA_W-1:0] : '0;
    assign err       = err_q;

    // Pack bits above DATA_W only exist to keep word writes aligned.
    assign unused_pack = ^pack;

endmodule

// File: tb/tb_ixc_context_write.sv
// Bench for ixc_context_write: a single-word (DATA_W=6) and a two-word
// (DATA_W=40) instance run side by side against a timeline model that
// predicts every output from the cycle count since the accepted start.
module tb_ixc_context_write;

    localparam int TMO = 15;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        start;
    logic        rd_en0, rd_en1;
    logic [0:0]  rd_addr0, rd_addr1;
    logic [31:0] rd_data0, rd_data1;
    logic [5:0]  ctx_wdata0;
    logic [39:0] ctx_wdata1;
    logic        ctx_we0, ctx_we1;
    logic        ctx_ack0, ctx_ack1;
    logic        busy0, busy1;
    logic        done0, done1;
    logic        err0, err1;

    ixc_context_write #(.DATA_W(6), .WORD_W(32), .ACK_TMO(TMO)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_data0),
        .ctx_wdata(ctx_wdata0), .ctx_we(ctx_we0), .ctx_ack(ctx_ack0),
        .busy(busy0), .done(done0), .err(err0)
    );

    ixc_context_write #(.DATA_W(40), .WORD_W(32), .ACK_TMO(TMO)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .ctx_wdata(ctx_wdata1), .ctx_we(ctx_we1), .ctx_ack(ctx_ack1),
        .busy(busy1), .done(done1), .err(err1)
    );

    // ---------------- scoreboard counters ----------------
    int vec_cnt;
    int err_cnt;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- timeline reference model ----------------
    // t_m: cycles since the accepted start (-1 = idle). Cycle 2k+1 reads word
    // k, cycle 2k+2 returns it, load cycles follow, fin_m is the done cycle.
    int          t_m[2];
    int          fin_m[2];
    int          nw_m[2];
    int          dw_m[2];
    int          last_m[2];
    bit          err_m[2];
    logic [31:0] words_m[2][2];
    logic [31:0] tbl[2][2];
    bit          use_tbl;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            t_m[i]    = -1;
            fin_m[i]  = -1;
            err_m[i]  = 1'b0;
            last_m[i] = 0;
        end
    endtask

    function automatic bit in_load(input int i);
        return (t_m[i] > 2 * nw_m[i]) && ((fin_m[i] < 0) || (t_m[i] < fin_m[i]));
    endfunction

    function automatic logic [63:0] exp_value(input int i);
        logic [63:0] v;
        v = (nw_m[i] == 1) ? {32'h0, words_m[i][0]} : {words_m[i][1], words_m[i][0]};
        return v & ((64'd1 << dw_m[i]) - 64'd1);
    endfunction

    // Advance model i across a clock edge using the inputs of the cycle just ended.
    task automatic model_edge(input int i, input bit st, input bit ack, input logic [31:0] rdd);
        int n;
        n = nw_m[i];
        if (t_m[i] < 0) begin
            if (st) begin
                t_m[i]   = 1;
                fin_m[i] = -1;
                err_m[i] = 1'b0;
            end
        end else if (t_m[i] == fin_m[i]) begin
            t_m[i] = -1;
        end else begin
            if ((t_m[i] >= 2) && (t_m[i] <= 2 * n) && (t_m[i] % 2 == 0))
                words_m[i][(t_m[i] - 2) / 2] = rdd;
            if (in_load(i)) begin
                if (ack) begin
                    fin_m[i] = t_m[i] + 1;
                end else if (t_m[i] - 2 * n == TMO) begin
                    fin_m[i] = t_m[i] + 1;
                    err_m[i] = 1'b1;
                end
            end
            t_m[i]++;
        end
    endtask

    task automatic check_outputs(input int i);
        bit          e_rd_en, e_we, e_done, e_busy;
        logic [63:0] e_wdata;
        logic [63:0] o_wdata;
        logic        o_rd_en, o_we, o_done, o_busy, o_err;
        logic [0:0]  o_addr;
        e_rd_en = (t_m[i] >= 1) && (t_m[i] <= 2 * nw_m[i]) && (t_m[i] % 2 == 1);
        if (e_rd_en) last_m[i] = (t_m[i] - 1) / 2;
        e_we    = in_load(i);
        e_done  = (t_m[i] >= 0) && (t_m[i] == fin_m[i]);
        e_busy  = (t_m[i] >= 1);
        e_wdata = e_we ? exp_value(i) : 64'd0;
        if (i == 0) begin
            o_rd_en = rd_en0; o_addr = rd_addr0; o_we = ctx_we0; o_wdata = 64'(ctx_wdata0);
            o_busy = busy0; o_done = done0; o_err = err0;
        end else begin
            o_rd_en = rd_en1; o_addr = rd_addr1; o_we = ctx_we1; o_wdata = 64'(ctx_wdata1);
            o_busy = busy1; o_done = done1; o_err = err1;
        end
        check_eq($sformatf("u%0d.rd_en", i),     64'(o_rd_en), 64'(e_rd_en));
        check_eq($sformatf("u%0d.rd_addr", i),   64'(o_addr),  64'(last_m[i]));
        check_eq($sformatf("u%0d.ctx_we", i),    64'(o_we),    64'(e_we));
        check_eq($sformatf("u%0d.ctx_wdata", i), o_wdata,      e_wdata);
        check_eq($sformatf("u%0d.busy", i),      64'(o_busy),  64'(e_busy));
        check_eq($sformatf("u%0d.done", i),      64'(o_done),  64'(e_done));
        check_eq($sformatf("u%0d.err", i),       64'(o_err),   64'(err_m[i]));
    endtask

    // ---------------- driver ----------------
    // ack_mode: 0 always, 1 never, 2 only on the final timeout cycle, 3 random.
    // start_mode: 0 none, 1 pulse on first cycle, 2 random, 3 held high.
    task automatic drive_inputs(input int ack_mode, input int start_mode, input bit first);
        bit          ack_v[2];
        logic [31:0] rdd_v[2];
        int          k;
        case (start_mode)
            1:       start = first;
            2:       start = ($urandom_range(0, 5) == 0);
            3:       start = 1'b1;
            default: start = 1'b0;
        endcase
        for (int i = 0; i < 2; i++) begin
            case (ack_mode)
                0:       ack_v[i] = 1'b1;
                2:       ack_v[i] = in_load(i) && (t_m[i] - 2 * nw_m[i] == TMO);
                3:       ack_v[i] = ($urandom_range(0, 6) == 0);
                default: ack_v[i] = 1'b0;
            endcase
            rdd_v[i] = $urandom;
            if ((t_m[i] >= 2) && (t_m[i] <= 2 * nw_m[i]) && (t_m[i] % 2 == 0)) begin
                k = (t_m[i] - 2) / 2;
                if (use_tbl) rdd_v[i] = tbl[i][k];
            end
        end
        ctx_ack0 = ack_v[0];
        ctx_ack1 = ack_v[1];
        rd_data0 = rdd_v[0];
        rd_data1 = rdd_v[1];
    endtask

    task automatic run_cycles(input int ncyc, input int ack_mode, input int start_mode);
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            model_edge(0, start, ctx_ack0, rd_data0);
            model_edge(1, start, ctx_ack1, rd_data1);
            #1;
            drive_inputs(ack_mode, start_mode, (c == 0));
            @(negedge clk);
            check_outputs(0);
            check_outputs(1);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vec_cnt  = 0;
        err_cnt  = 0;
        nw_m[0]  = 1;  dw_m[0] = 6;
        nw_m[1]  = 2;  dw_m[1] = 40;
        tbl[0][0] = 32'hFFFF_FFE5;
        tbl[0][1] = 32'h0000_0000;
        tbl[1][0] = 32'h1234_5678;
        tbl[1][1] = 32'hFFFF_FFAB;
        use_tbl  = 1'b0;
        model_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        ctx_ack0 = 1'b0;
        ctx_ack1 = 1'b0;
        rd_data0 = '0;
        rd_data1 = '0;

        // Reset state.
        @(negedge clk);
        check_outputs(0);
        check_outputs(1);
        run_cycles(2, 1, 0);
        rst_n = 1'b1;
        run_cycles(2, 1, 0);

        // Known words, ack on the first load cycle.
        use_tbl = 1'b1;
        run_cycles(12, 0, 1);
        use_tbl = 1'b0;

        // No ack: full timeout, then a fresh start clears err.
        run_cycles(25, 1, 1);
        run_cycles(12, 0, 1);

        // Ack on exactly the timeout cycle.
        run_cycles(25, 2, 1);

        // start held high: re-requests while busy and in FIN are ignored.
        run_cycles(60, 3, 3);

        // Random traffic.
        run_cycles(600, 3, 2);
        run_cycles(30, 0, 0);

        // Reset dropped while both instances are in LOAD.
        run_cycles(8, 1, 1);
        @(posedge clk);
        model_edge(0, start, ctx_ack0, rd_data0);
        model_edge(1, start, ctx_ack1, rd_data1);
        #3;
        rst_n = 1'b0;
        model_reset();
        start    = 1'b0;
        ctx_ack0 = 1'b0;
        ctx_ack1 = 1'b0;
        #1;
        check_outputs(0);
        check_outputs(1);
        run_cycles(3, 1, 0);
        rst_n = 1'b1;
        run_cycles(12, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
